if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, PC/address width.
REQ-002 Parameter DEPTH, default 4, fetch-queue entries, power of two, >=2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ebreak_E  in  1  halt request from execute.
REQ-008 redirect_E  in  1  branch/jump taken, new target valid.
REQ-009 PCin1_E  in  XLEN  target base.
REQ-010 immediate_E  in  XLEN  target offset.
REQ-011 imem_req_valid  out  1  fetch request.
REQ-012 imem_req_addr  out  XLEN  fetch address.
REQ-013 imem_req_ready  in  1  memory accepts request.
REQ-014 imem_rsp_valid  in  1  response data valid.
REQ-015 imem_rsp_data  in  32  fetched instruction.
REQ-016 instr_valid_F  out  1  queue head valid.
REQ-017 instruction_F  out  32  queue-head instruction.
REQ-018 PC_F  out  XLEN  queue-head PC.
REQ-019 PCplus4_F  out  XLEN  PC_F + 4, mod 2^XLEN.
REQ-020 instr_ready_D  in  1  decode consumes head.
REQ-021 halted  out  1  ebreak halt state.

Function
REQ-022 States RUN and HALT; RUN->HALT on ebreak_E; HALT exits only on rst.
REQ-023 At most one outstanding request; responses arrive in order, >=1 cycle after acceptance.
REQ-024 imem_req_valid=1 iff state RUN, no redirect/ebreak this cycle, and (occupancy + outstanding) < DEPTH; a response arriving this cycle clears outstanding for this test.
REQ-025 Request accepted on imem_req_valid & imem_req_ready; fetch PC then advances by 4 (wrap mod 2^XLEN); request address/valid SHALL hold stable until accepted.
REQ-026 Accepted request's PC is held in a pending register; matching response pushes {pc, instr} into queue same edge.
REQ-027 Queue head pops on instr_valid_F & instr_ready_D; simultaneous push and pop leaves occupancy unchanged.
REQ-028 Redirect target = PCin1_E + immediate_E mod 2^XLEN with bits [1:0] forced to 0.
REQ-029 On redirect_E: queue flushed, fetch PC <= target, outstanding response marked stale and discarded on arrival; applies regardless of queue fullness.
REQ-030 On ebreak_E: queue flushed, outstanding response discarded, halted=1 next cycle, no further requests.
REQ-031 ebreak_E and redirect_E same cycle: ebreak wins, target ignored.
REQ-032 instruction_F/PC_F SHALL be don't-care when instr_valid_F=0; no combinational path from imem_rsp_* to instr_valid_F.

Reset
REQ-033 During rst: fetch PC=RESET_PC, queue empty, outstanding=0, state RUN, halted=0, instr_valid_F=0, imem_req_valid=0.
REQ-034 rst mid-operation SHALL drop queue and pending response; first request (addr RESET_PC) asserted the cycle after rst deasserts.

Structure
REQ-035 Shared package if_pkg SHALL hold XLEN default, state enum {RUN, HALT}, queue-entry struct {pc, instr}.
REQ-036 Queue SHALL be sub-module fetch_queue: circular FIFO, DEPTH entries, wrap-around pointers, flush input.
REQ-037 Target adder SHALL be plain XLEN-bit addition, no carry out.

Verification
REQ-038 Reset, memory ready and 1-cycle response, decode ready -> addresses 0,4,8,12 issued back-to-back; PC_F 0,4,8 one per cycle.
REQ-039 instr_ready_D=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; occupancy 4, no loss.
REQ-040 redirect_E with PCin1_E=0x100, immediate_E=0x23 while request outstanding -> stale response dropped, next request addr 0x120, next PC_F 0x120.
REQ-041 PCin1_E=0xFFFF_FFFC, immediate_E=8 -> target 0x0000_0004 (wrap).
REQ-042 ebreak_E and redirect_E same cycle -> halted=1 next cycle, queue empty, no further requests until rst; rst -> request addr RESET_PC.
REQ-043 imem_req_ready=0 for 3 cycles -> imem_req_addr stable, single acceptance, PC advances once.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction fetch unit: fetch state and fetch-queue entry layout.
package if_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // The pc field is XLEN_DEFAULT wide, so the fetch unit supports XLEN up to XLEN_DEFAULT.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries with wrap-around pointers and a flush input.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fq_entry_t                push_entry,
    input  logic                     pop,
    output logic                     head_valid,
    output fq_entry_t                head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head_valid = (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, fetch queue toward decode,
// redirect on taken branches and a sticky halt on ebreak.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ebreak_E,
    input  logic            redirect_E,
    input  logic [XLEN-1:0] PCin1_E,
    input  logic [XLEN-1:0] immediate_E,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid_F,
    output logic [31:0]     instruction_F,
    output logic [XLEN-1:0] PC_F,
    output logic [XLEN-1:0] PCplus4_F,
    input  logic            instr_ready_D,
    output logic            halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e          state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pending_pc_q;
    logic            outstanding_q;
    logic            stale_q;

    logic            running;
    logic            flush;
    logic            rsp_hit;
    logic            push;
    logic            pop;
    logic            req_fire;
    logic            out_busy;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;
    logic            head_valid;
    fq_entry_t       push_entry;
    fq_entry_t       head_entry;

    assign running    = (state_q == RUN);
    assign target_sum = PCin1_E + immediate_E;
    assign target     = {target_sum[XLEN-1:2], 2'b00};
    assign flush      = ebreak_E | (redirect_E & running);

    assign rsp_hit  = imem_rsp_valid & outstanding_q;
    assign push     = rsp_hit & ~stale_q & running & ~flush;
    assign out_busy = outstanding_q & ~imem_rsp_valid;
    // An arriving response moves from "outstanding" into the queue, so count it once.
    assign occ      = count + CW'(push);

    assign imem_req_valid = ~rst & running & ~redirect_E & ~ebreak_E & ~out_busy
                            & (occ < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = XLEN_DEFAULT'(pending_pc_q);
        push_entry.instr = imem_rsp_data;
    end

    assign instr_valid_F = head_valid & ~rst;
    assign instruction_F = head_entry.instr;
    assign PC_F          = head_entry.pc[XLEN-1:0];
    assign PCplus4_F     = PC_F + XLEN'(4);
    assign pop           = instr_valid_F & instr_ready_D;
    assign halted        = (state_q == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            pending_pc_q  <= '0;
            outstanding_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            if (ebreak_E) state_q <= HALT;
            if (running && !ebreak_E) begin
                if (redirect_E)    fetch_pc_q <= target;
                else if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
            end
            if (req_fire) pending_pc_q <= fetch_pc_q;
            // A flush with a request in flight leaves its response to be dropped on arrival.
            if (req_fire) begin
                outstanding_q <= 1'b1;
                stale_q       <= 1'b0;
            end else if (rsp_hit) begin
                outstanding_q <= 1'b0;
                stale_q       <= 1'b0;
            end else if (flush && outstanding_q) begin
                stale_q <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .count      (count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed sequences, a redirect-target table and
// randomized traffic against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        ebreak_E;
    logic        redirect_E;
    logic [31:0] PCin1_E;
    logic [31:0] immediate_E;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid_F;
    logic [31:0] instruction_F;
    logic [31:0] PC_F;
    logic [31:0] PCplus4_F;
    logic        instr_ready_D;
    logic        halted;

    if_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ebreak_E       (ebreak_E),
        .redirect_E     (redirect_E),
        .PCin1_E        (PCin1_E),
        .immediate_E    (immediate_E),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid_F  (instr_valid_F),
        .instruction_F  (instruction_F),
        .PC_F           (PC_F),
        .PCplus4_F      (PCplus4_F),
        .instr_ready_D  (instr_ready_D),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Model state: program-order list of PCs decode should still see, next fetch address,
    // halt flag, and a single-slot memory that answers after a latency.
    logic [31:0] exp_q[$];
    logic [31:0] next_addr;
    bit          halted_m;
    int          rsp_timer;
    logic [31:0] rsp_addr;
    int          lat_cfg;
    bit          lat_rand;
    bit          stall_prev;
    logic [31:0] stall_addr;

    bit          s_rv;
    logic [31:0] s_ra;
    bit          s_iv;
    logic [31:0] s_pc;
    bit          s_halt;
    bit          s_fire;
    bit          s_pop;

    typedef struct {
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] target;
    } tgt_vec_t;

    tgt_vec_t tv[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        if (rsp_timer == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(rsp_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        s_rv   = imem_req_valid;
        s_ra   = imem_req_addr;
        s_iv   = instr_valid_F;
        s_pc   = PC_F;
        s_halt = halted;
        s_fire = s_rv & imem_req_ready;
        s_pop  = s_iv & instr_ready_D;

        check("halted_flag", s_halt, halted_m);
        if (halted_m) begin
            check("no_req_halted", s_rv, 0);
            check("empty_halted", s_iv, 0);
        end
        if (redirect_E || ebreak_E) check("no_req_on_flush", s_rv, 0);
        if (stall_prev && !redirect_E && !ebreak_E) begin
            check("hold_valid", s_rv, 1);
            check("hold_addr", s_ra, stall_addr);
        end
        if (s_pop) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                check("pop_pc", s_pc, exp_q[0]);
                check("pop_instr", instruction_F, mem_word(s_pc));
                check("pop_pcplus4", PCplus4_F, s_pc + 32'd4);
                void'(exp_q.pop_front());
            end
        end
        if (rsp_timer > 0) rsp_timer--;
        if (ebreak_E) begin
            exp_q.delete();
            halted_m = 1'b1;
        end else if (redirect_E && !halted_m) begin
            exp_q.delete();
            next_addr = (PCin1_E + immediate_E) & ~32'h3;
        end else if (s_fire) begin
            check("req_addr", s_ra, next_addr);
            check("one_outstanding", rsp_timer == 0, 1);
            exp_q.push_back(s_ra);
            next_addr = s_ra + 32'd4;
            check("occupancy_bound", exp_q.size() <= DEPTH, 1);
            rsp_timer = lat_rand ? int'($urandom_range(3, 1)) : lat_cfg;
            rsp_addr  = s_ra;
        end
        stall_prev = s_rv & ~imem_req_ready;
        stall_addr = s_ra;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        ebreak_E       = 1'b0;
        redirect_E     = 1'b0;
        imem_rsp_valid = 1'b0;
        rsp_timer      = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_req_valid", imem_req_valid, 0);
            check("rst_instr_valid", instr_valid_F, 0);
            if (i > 0) check("rst_halted", halted, 0);
            @(posedge clk);
            #1;
        end
        rst        = 1'b0;
        exp_q.delete();
        next_addr  = RST_PC;
        halted_m   = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic idle_inputs();
        ebreak_E       = 1'b0;
        redirect_E     = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready_D  = 1'b1;
        PCin1_E        = '0;
        immediate_E    = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rv[5];
        logic [31:0] ra[5];
        bit          iv[5];
        logic [31:0] pc[5];
        int          fires;
        bit          seen;

        total = 0;
        bad   = 0;
        lat_cfg  = 1;
        lat_rand = 1'b0;
        rst = 1'b1;
        idle_inputs();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        tv[0] = '{32'h0000_0100, 32'h0000_0023, 32'h0000_0120};
        tv[1] = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004};
        tv[2] = '{32'h0000_1000, 32'hFFFF_FFF0, 32'h0000_0FF0};
        tv[3] = '{32'h0000_0007, 32'h0000_0002, 32'h0000_0008};
        tv[4] = '{32'h8000_0003, 32'h7FFF_FFFF, 32'h0000_0000};

        // Back-to-back streaming from reset.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            cycle();
            rv[i] = s_rv;
            ra[i] = s_ra;
            iv[i] = s_iv;
            pc[i] = s_pc;
        end
        check("stream_first_empty", iv[0], 0);
        for (int i = 0; i < 4; i++) begin
            check("stream_req_valid", rv[i], 1);
            check("stream_req_addr", ra[i], 32'(4 * i));
        end
        for (int i = 2; i < 5; i++) begin
            check("stream_pc_valid", iv[i], 1);
            check("stream_pc", pc[i], 32'(4 * (i - 2)));
        end

        // Decode stalled: queue fills to DEPTH and requests stop.
        do_reset(1);
        instr_ready_D = 1'b0;
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_fire) fires++;
        end
        check("stall_fires", fires, DEPTH);
        check("stall_req_off", s_rv, 0);
        instr_ready_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("drain_valid", s_iv, 1);
            check("drain_pc", s_pc, 32'(4 * i));
        end

        // Redirect target table.
        do_reset(1);
        idle_inputs();
        repeat (3) cycle();
        for (int k = 0; k < 5; k++) begin
            redirect_E  = 1'b1;
            PCin1_E     = tv[k].base;
            immediate_E = tv[k].off;
            cycle();
            redirect_E = 1'b0;
            cycle();
            check("tgt_req_valid", s_rv, 1);
            check("tgt_req_addr", s_ra, tv[k].target);
            repeat (3) cycle();
        end

        // Redirect while a slow response is outstanding.
        do_reset(1);
        idle_inputs();
        lat_cfg = 3;
        cycle();
        check("slow_first_fire", s_fire, 1);
        redirect_E  = 1'b1;
        PCin1_E     = 32'h100;
        immediate_E = 32'h23;
        cycle();
        redirect_E = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = s_fire;
        end
        check("redir_fire_seen", seen, 1);
        check("redir_fire_addr", s_ra, 32'h120);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = s_iv;
        end
        check("redir_head_seen", seen, 1);
        check("redir_head_pc", s_pc, 32'h120);
        lat_cfg = 1;

        // Memory not ready for three cycles.
        do_reset(1);
        idle_inputs();
        imem_req_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_req_valid", s_rv, 1);
            check("bp_req_addr", s_ra, RST_PC);
        end
        imem_req_ready = 1'b1;
        cycle();
        if (s_fire) fires++;
        imem_req_ready = 1'b0;
        cycle();
        if (s_fire) fires++;
        check("bp_single_accept", fires, 1);
        check("bp_next_addr", s_ra, RST_PC + 32'd4);

        // ebreak and redirect together: ebreak wins, halt until reset.
        do_reset(1);
        idle_inputs();
        repeat (6) cycle();
        ebreak_E    = 1'b1;
        redirect_E  = 1'b1;
        PCin1_E     = 32'h200;
        immediate_E = 32'h4;
        cycle();
        ebreak_E   = 1'b0;
        redirect_E = 1'b0;
        cycle();
        check("halt_set", s_halt, 1);
        check("halt_empty", s_iv, 0);
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_rv) fires++;
        end
        check("halt_no_req", fires, 0);
        do_reset(1);
        cycle();
        check("post_halt_req_valid", s_rv, 1);
        check("post_halt_req_addr", s_ra, RST_PC);

        // Randomized traffic against the model.
        do_reset(1);
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(999, 0));
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready_D  = ($urandom_range(4, 0) < 3);
            redirect_E     = (r < 30);
            ebreak_E       = (r >= 30 && r < 34);
            PCin1_E        = $urandom;
            immediate_E    = $urandom;
            if ((r >= 34 && r < 38) || (halted_m && $urandom_range(7, 0) == 0)) begin
                do_reset(int'($urandom_range(2, 1)));
            end else begin
                cycle();
            end
        end
        lat_rand = 1'b0;
        idle_inputs();
        repeat (30) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
